blocked_cache: RTL and testbench
================================

BLOCKED_CACHE -- requirements
Module: blocked_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16: number of sets; power of two, at least 2.
REQ-002 SHALL have parameter BLOCK_WORDS, default 4: 32-bit words per line; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port addr, input, [31:2]: CPU word address.
REQ-006 SHALL have ports read_en and write_en, input, 1 bit each: CPU access strobes.
REQ-007 SHALL have ports write_data (input) and read_data (output), 32 bits each: CPU data.
REQ-008 SHALL have port stall, output, 1 bit: access not complete; CPU holds addr/strobes/write_data stable while high.
REQ-009 SHALL have ports mem_req and mem_we, output, 1 bit each: backing-memory request and write qualifier.
REQ-010 SHALL have port mem_addr, output, [31:2]: backing-memory word address.
REQ-011 SHALL have ports mem_wdata (output) and mem_rdata (input), 32 bits each: backing-memory data.
REQ-012 SHALL have port mem_ack, input, 1 bit: memory completes the current word in the cycle it is high while mem_req is high.

Function
REQ-013 SHALL be 2-way set-associative, write-back, write-allocate, with 1 LRU bit per set.
REQ-014 SHALL split addr as follows:
- offset = addr[OW+1:2], where OW = log2(BLOCK_WORDS);
- set = next log2(NUM_SETS) bits;
- tag = remaining upper bits.
REQ-015 SHALL treat read_en and write_en both high as a write.
REQ-016 SHALL use FSM states IDLE, WB, FILL and DONE.
REQ-017 SHALL handle a hit in IDLE in zero cycles:
- stall=0;
- read_data = hit word, combinational;
- a write updates the word and sets the dirty bit;
- LRU points to the other way.
REQ-018 SHALL, on a miss in IDLE, assert stall combinationally in the same cycle and select the victim as invalid way 0, else invalid way 1, else the LRU way.
REQ-019 SHALL go IDLE->WB if the victim is valid and dirty, otherwise IDLE->FILL.
REQ-020 SHALL, in WB, issue BLOCK_WORDS writes:
- mem_we=1;
- mem_addr = {victim tag, set, counter};
- mem_wdata = victim word[counter].
REQ-021 SHALL, in FILL, issue BLOCK_WORDS reads with mem_we=0 and mem_addr = {addr tag, set, counter}, writing mem_rdata into the line word[counter] on each ack.
REQ-022 SHALL hold mem_req, mem_addr, mem_we and mem_wdata stable until mem_ack; the word counter advances only on ack.
REQ-023 SHALL, after the last ack, reset the counter to 0 and go WB->FILL or FILL->DONE.
REQ-024 SHALL, at the last FILL ack, set the line valid, write its tag and clear dirty.
REQ-025 SHALL complete the held access in DONE as in REQ-017, with stall=0 and mem_req=0, then return to IDLE.
REQ-026 SHALL drive stall=1 in WB and FILL regardless of ack.
REQ-027 SHALL drive read_data=0 when no access is enabled and during stall; mem_req=0 in IDLE and DONE.
REQ-028 SHALL accept an ack arriving in the same cycle mem_req first rises; back-to-back acks give 1 word per cycle.
REQ-029 SHALL NOT allow a line to be hit while it is being filled.

Reset
REQ-030 SHALL, on rst (including mid-WB/FILL), set state to IDLE, counter to 0 and mem_req=0 next cycle.
REQ-031 SHALL clear all valid, dirty and LRU bits on rst; data and tag arrays need not be cleared.
REQ-032 SHALL discard any partially filled line on rst; it stays invalid.
REQ-033 SHALL drive these output values after reset: stall=0 unless an access is presented, read_data=0 with no access, mem_we=0, mem_addr=0, mem_wdata=0.

Configuration
REQ-034 SHALL, with macro CACHE_STATS_EN defined, add two outputs hit_count[31:0] and miss_count[31:0].
REQ-035 SHALL increment hit_count once per IDLE-cycle hit and miss_count once per IDLE->WB/FILL transition; DONE cycles count neither.
REQ-036 SHALL saturate both counters at 0xFFFFFFFF and clear them on rst.
REQ-037 SHALL, without CACHE_STATS_EN, have neither the ports nor the counter logic; all other behaviour is identical.

Verification
REQ-038 SHALL cover cold read miss: read addr 0x40 (word address); memory acks 4 cycles later per word -> 4 reads at 0x40..0x43, then DONE returns mem[0x40], stall drops.
REQ-039 SHALL cover read hit: reread 0x41 -> stall=0 same cycle, data = mem[0x41], mem_req=0.
REQ-040 SHALL cover write-back eviction: write 0xDEADBEEF to 0x40, then miss to tags mapping set 0 twice (0x440, 0x840) -> second miss issues 4 writes at 0x40..0x43 carrying 0xDEADBEEF at 0x40 before its fill.
REQ-041 SHALL cover LRU: fill 0x40 and 0x440, read 0x40, miss 0x840 -> 0x440 is evicted and 0x40 still hits.
REQ-042 SHALL cover reset mid-FILL: assert rst after the 2nd ack -> next cycle mem_req=0 and stall=0, and a subsequent read of 0x40 misses again.
REQ-043 SHALL cover stats (with CACHE_STATS_EN): the sequence in REQ-038/REQ-039 -> miss_count=1, hit_count=1.

Source files
------------

// File: rtl/blocked_cache.sv
// 2-way set-associative, write-back, write-allocate blocking cache with 1 LRU bit per set.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module blocked_cache #(
    parameter int NUM_SETS    = 16,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] addr,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:2] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int SW = $clog2(NUM_SETS);
    localparam int TW = 30 - OW - SW;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t                state_q;
    logic [OW-1:0]         cnt_q;
    logic                  way_q;
    logic [NUM_SETS-1:0]   valid_q [2];
    logic [NUM_SETS-1:0]   dirty_q [2];
    logic [NUM_SETS-1:0]   lru_q;
    logic [TW-1:0]         tag_q   [2][NUM_SETS];
    logic [31:0]           data_q  [2][NUM_SETS][BLOCK_WORDS];
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [29:0]           mem_addr_q;
    logic [31:0]           mem_wdata_q;

    logic [OW-1:0] off_s;
    logic [SW-1:0] set_s;
    logic [TW-1:0] tag_s;
    logic          access_s;
    logic          hit0_s;
    logic          hit1_s;
    logic          hit_s;
    logic          hit_way_s;
    logic          miss_s;
    logic          victim_s;
    logic          victim_dirty_s;
    logic          cnt_last_s;
    logic [OW-1:0] cnt_nxt_s;
    logic [OW-1:0] cnt_zero_s;

    assign off_s      = addr[OW+1:2];
    assign set_s      = addr[OW+SW+1:OW+2];
    assign tag_s      = addr[31:OW+SW+2];
    assign access_s   = read_en | write_en;
    assign cnt_zero_s = {OW{1'b0}};
    assign cnt_nxt_s  = cnt_q + {{(OW-1){1'b0}}, 1'b1};
    assign cnt_last_s = (cnt_q == {OW{1'b1}});

    // Tag lookup is only meaningful in IDLE and DONE; a line under fill has been invalidated.
    always_comb begin
        hit0_s    = valid_q[0][set_s] && (tag_q[0][set_s] == tag_s);
        hit1_s    = valid_q[1][set_s] && (tag_q[1][set_s] == tag_s);
        hit_way_s = !hit0_s;
        hit_s     = ((state_q == IDLE) || (state_q == DONE)) && access_s && (hit0_s || hit1_s);
        miss_s    = (state_q == IDLE) && access_s && !(hit0_s || hit1_s);
        if (!valid_q[0][set_s]) begin
            victim_s = 1'b0;
        end else if (!valid_q[1][set_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_q[set_s];
        end
        victim_dirty_s = valid_q[victim_s][set_s] && dirty_q[victim_s][set_s];
    end

    // CPU-facing outputs: zero-cycle hit data and stall.
    always_comb begin
        if (hit_s) begin
            read_data = data_q[hit_way_s][set_s][off_s];
        end else begin
            read_data = 32'h0000_0000;
        end
        case (state_q)
            IDLE:    stall = miss_s;
            WB:      stall = 1'b1;
            FILL:    stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Controller FSM, line state and registered memory-request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {OW{1'b0}};
            way_q       <= 1'b0;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            dirty_q[0]  <= '0;
            dirty_q[1]  <= '0;
            lru_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 30'd0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            if (hit_s) begin
                if (write_en) begin
                    data_q[hit_way_s][set_s][off_s] <= write_data;
                    dirty_q[hit_way_s][set_s]       <= 1'b1;
                end
                lru_q[set_s] <= !hit_way_s;
            end
            case (state_q)
                IDLE: begin
                    if (miss_s) begin
                        way_q     <= victim_s;
                        cnt_q     <= {OW{1'b0}};
                        mem_req_q <= 1'b1;
                        if (victim_dirty_s) begin
                            state_q     <= WB;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[victim_s][set_s], set_s, cnt_zero_s};
                            mem_wdata_q <= data_q[victim_s][set_s][0];
                        end else begin
                            state_q                 <= FILL;
                            valid_q[victim_s][set_s] <= 1'b0;
                            mem_we_q                <= 1'b0;
                            mem_addr_q              <= {tag_s, set_s, cnt_zero_s};
                            mem_wdata_q             <= 32'h0000_0000;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        if (cnt_last_s) begin
                            cnt_q                 <= {OW{1'b0}};
                            state_q               <= FILL;
                            valid_q[way_q][set_s] <= 1'b0;
                            mem_we_q              <= 1'b0;
                            mem_addr_q            <= {tag_s, set_s, cnt_zero_s};
                            mem_wdata_q           <= 32'h0000_0000;
                        end else begin
                            cnt_q       <= cnt_nxt_s;
                            mem_addr_q  <= {tag_q[way_q][set_s], set_s, cnt_nxt_s};
                            mem_wdata_q <= data_q[way_q][set_s][cnt_nxt_s];
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        data_q[way_q][set_s][cnt_q] <= mem_rdata;
                        if (cnt_last_s) begin
                            cnt_q                 <= {OW{1'b0}};
                            state_q               <= DONE;
                            valid_q[way_q][set_s] <= 1'b1;
                            dirty_q[way_q][set_s] <= 1'b0;
                            tag_q[way_q][set_s]   <= tag_s;
                            mem_req_q             <= 1'b0;
                            mem_addr_q            <= 30'd0;
                        end else begin
                            cnt_q      <= cnt_nxt_s;
                            mem_addr_q <= {tag_s, set_s, cnt_nxt_s};
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit/miss counters; DONE-cycle completions are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'h0000_0000;
            miss_cnt_q <= 32'h0000_0000;
        end else begin
            if ((state_q == IDLE) && hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_blocked_cache.sv
// Self-checking bench for blocked_cache: a line-level cache model predicts memory traffic and hit data.
module tb_blocked_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic        read_en;
    logic        write_en;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    blocked_cache #(.NUM_SETS(16), .BLOCK_WORDS(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
        .write_data(write_data), .read_data(read_data), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    typedef struct packed {logic we; logic [29:0] a; logic [31:0] d;} op_t;
    typedef struct packed {logic [3:0] set; logic [23:0] tag; logic [127:0] data; logic dirty;} line_t;

    int          checks = 0;
    int          errors = 0;
    op_t         exp_q[$];
    op_t         obs_q[$];
    line_t       lines[$];
    logic [31:0] mem_m [int];
    bit          act = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    int          ack_delay = 4;
    int          cyc;
    logic [31:0] rd;

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (mem_m.exists(int'(a))) return mem_m[int'(a)];
        return {2'b10, a} ^ 32'h5A5A_0000;
    endfunction

    // Line-level model: lines kept in most-recently-used-first order, at most two per set.
    function automatic bit model_access(input logic [29:0] a, input bit we, input logic [31:0] wd);
        logic [3:0]  s;
        logic [23:0] t;
        int          off;
        int          idx;
        int          cnt;
        int          last;
        line_t       ln;
        logic [29:0] wa;
        bit          hit;
        s = a[5:2]; t = a[29:6]; off = int'(a[1:0]);
        idx = -1; cnt = 0; last = -1;
        for (int i = 0; i < lines.size(); i++) begin
            if (lines[i].set == s && lines[i].tag == t && idx < 0) idx = i;
            if (lines[i].set == s) begin cnt++; last = i; end
        end
        hit = (idx >= 0);
        if (hit) begin
            ln = lines[idx];
            lines.delete(idx);
        end else begin
            if (cnt == 2) begin
                ln = lines[last];
                if (ln.dirty) begin
                    for (int w = 0; w < 4; w++) begin
                        wa = {ln.tag, s, 2'(w)};
                        exp_q.push_back({1'b1, wa, ln.data[32*w +: 32]});
                        mem_m[int'(wa)] = ln.data[32*w +: 32];
                    end
                end
                lines.delete(last);
            end
            ln.set = s; ln.tag = t; ln.dirty = 1'b0;
            for (int w = 0; w < 4; w++) begin
                wa = {t, s, 2'(w)};
                ln.data[32*w +: 32] = mem_rd(wa);
                exp_q.push_back({1'b0, wa, 32'h0});
            end
        end
        exp_rdata = ln.data[32*off +: 32];
        if (we) begin
            ln.data[32*off +: 32] = wd;
            ln.dirty = 1'b1;
        end
        lines.push_front(ln);
        return hit;
    endfunction

    // Per-cycle comparison of all DUT outputs against the model's expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (act) begin
                if (exp_q.size() > 0) chk("stall_pending", 64'(stall), 64'd1);
                else begin
                    chk("stall_done", 64'(stall), 64'd0);
                    chk("read_data", 64'(read_data), 64'(exp_rdata));
                end
            end else begin
                chk("stall_idle", 64'(stall), 64'd0);
                chk("read_data_idle", 64'(read_data), 64'd0);
            end
            if (mem_req) begin
                if (exp_q.size() == 0) chk("mem_req_spurious", 64'(mem_req), 64'd0);
                else begin
                    chk("mem_we", 64'(mem_we), 64'(exp_q[0].we));
                    chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].a));
                    if (exp_q[0].we) chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].d));
                    if (mem_ack) begin
                        obs_q.push_back({mem_we, mem_addr, mem_wdata});
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("mem_we_idle", 64'(mem_we), 64'd0);
                chk("mem_addr_idle", 64'(mem_addr), 64'd0);
                chk("mem_wdata_idle", 64'(mem_wdata), 64'd0);
            end
        end
    end

    // Backing memory: acks ack_delay cycles after each word request (0 = same cycle).
    initial begin
        int wcnt;
        wcnt = 0; mem_ack = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = mem_rd(mem_addr); wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; act = 1'b0; read_en = 1'b0; write_en = 1'b0;
        lines.delete(); exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic access(input logic [29:0] a, input bit we, input bit both, input logic [31:0] wd,
                          output int cyc_o, output logic [31:0] rd_o);
        bit done_b;
        void'(model_access(a, we, wd));
        addr = a; write_en = we; read_en = !we || both; write_data = wd; act = 1'b1;
        cyc_o = 0; done_b = 1'b0; rd_o = 32'h0;
        repeat (300) begin
            if (!done_b) begin
                @(negedge clk);
                if (!stall) begin done_b = 1'b1; rd_o = read_data; end
                else cyc_o++;
            end
        end
        if (!done_b) chk("access_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        read_en = 1'b0; write_en = 1'b0; act = 1'b0;
    endtask

    initial begin
        bit done_b;
        rst = 1'b1; addr = 30'h0; read_en = 1'b0; write_en = 1'b0; write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk); #1;

        // Cold read miss, slow memory.
        ack_delay = 4; obs_q.delete();
        access(30'h40, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("cold_miss_stalled", 64'(cyc > 0), 64'd1);
        chk("cold_fill_words", 64'(obs_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            chk("cold_fill_addr", 64'(obs_q[i].a), 64'(30'h40 + 30'(i)));
            chk("cold_fill_we", 64'(obs_q[i].we), 64'd0);
        end
        chk("cold_rdata", 64'(rd), 64'hDA5A_0040);

        // Read hit in the same line.
        obs_q.delete();
        access(30'h41, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("hit_cycles", 64'(cyc), 64'd0);
        chk("hit_rdata", 64'(rd), 64'hDA5A_0041);
        chk("hit_no_mem", 64'(obs_q.size()), 64'd0);
`ifdef CACHE_STATS_EN
        chk("stats_miss", 64'(miss_count), 64'd1);
        chk("stats_hit", 64'(hit_count), 64'd1);
`endif

        // Write-back eviction with back-to-back acks.
        ack_delay = 0;
        access(30'h40, 1'b1, 1'b0, 32'hDEAD_BEEF, cyc, rd);
        chk("write_hit_cycles", 64'(cyc), 64'd0);
        obs_q.delete();
        access(30'h440, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("clean_fill_words", 64'(obs_q.size()), 64'd4);
        chk("b2b_fill_cycles", 64'(cyc), 64'd5);
        obs_q.delete();
        access(30'h840, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("wb_total_words", 64'(obs_q.size()), 64'd8);
        chk("b2b_wb_cycles", 64'(cyc), 64'd9);
        if (obs_q.size() == 8) begin
            chk("wb_first", 64'(obs_q[0]), 64'({1'b1, 30'h40, 32'hDEAD_BEEF}));
            chk("wb_last_addr", 64'(obs_q[3].a), 64'h43);
            chk("wb_then_fill_we", 64'(obs_q[4].we), 64'd0);
            chk("wb_then_fill_addr", 64'(obs_q[4].a), 64'h840);
        end

        // LRU replacement.
        do_reset();
        access(30'h40, 1'b0, 1'b0, 32'h0, cyc, rd);
        access(30'h440, 1'b0, 1'b0, 32'h0, cyc, rd);
        access(30'h40, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("lru_rehit_cycles", 64'(cyc), 64'd0);
        chk("lru_rehit_rdata", 64'(rd), 64'hDEAD_BEEF);
        obs_q.delete();
        access(30'h840, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("lru_clean_evict_words", 64'(obs_q.size()), 64'd4);
        access(30'h40, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("lru_keeps_mru", 64'(cyc), 64'd0);
        access(30'h440, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("lru_evicted_misses", 64'(cyc > 0), 64'd1);

        // Reset in the middle of a fill.
        do_reset();
        ack_delay = 4; obs_q.delete();
        void'(model_access(30'h40, 1'b0, 32'h0));
        addr = 30'h40; read_en = 1'b1; act = 1'b1; done_b = 1'b0;
        repeat (100) begin
            if (!done_b) begin
                @(negedge clk);
                if (obs_q.size() >= 2) done_b = 1'b1;
            end
        end
        chk("midfill_two_acks", 64'(done_b), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; read_en = 1'b0; act = 1'b0; lines.delete(); exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midfill_mem_req", 64'(mem_req), 64'd0);
        chk("midfill_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        obs_q.delete();
        access(30'h40, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("midfill_remiss", 64'(cyc > 0), 64'd1);
        chk("midfill_refill_words", 64'(obs_q.size()), 64'd4);

        // Write-allocate miss on the last set and last word, both strobes high.
        ack_delay = 2;
        access(30'h3F, 1'b1, 1'b1, 32'h0BAD_F00D, cyc, rd);
        chk("write_miss_stalled", 64'(cyc > 0), 64'd1);
        access(30'h3F, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("write_alloc_rdata", 64'(rd), 64'h0BAD_F00D);
        chk("write_alloc_hit", 64'(cyc), 64'd0);
        access(30'h3C, 1'b0, 1'b0, 32'h0, cyc, rd);
        chk("same_line_word0", 64'(rd), 64'hDA5A_003C);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
